// File: rtl/branch_resolve_queue.sv
// In-order branch resolution queue: tracks predicted branches, trains the predictor, flushes on mispredict.
// Latency: enqueue→resolvable 1 cycle; resolve→update_en/mispredict 1 cycle (registered).
// Backpressure: pred_rdy low when full or flushing; res_rdy low when empty or flushing; no bypass either way.
module branch_resolve_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_val,
    output logic                       pred_rdy,
    input  logic [31:0]                pred_pc,
    input  logic                       pred_taken,
    input  logic                       res_val,
    output logic                       res_rdy,
    input  logic                       res_taken,
    output logic                       update_en,
    output logic                       update_val,
    output logic                       mispredict,
    output logic [31:0]                mispredict_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                resolved_cnt,
    output logic [31:0]                mispred_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [31:0]        pc_mem    [DEPTH];
    logic               taken_mem [DEPTH];

    logic               enq;
    logic               deq;
    logic               mis;
    logic               head_taken;
    logic [31:0]        head_pc;

    assign pred_rdy   = reset && (state == RUN) && (count < FULL_CNT);
    assign res_rdy    = reset && (state == RUN) && (count != '0);
    assign enq        = pred_val && pred_rdy;
    assign deq        = res_val && res_rdy;
    assign head_taken = taken_mem[head];
    assign head_pc    = pc_mem[head];
    assign mis        = deq && (res_taken != head_taken);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mis) state_nxt = FLUSH;
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // A mispredicting resolve squashes every younger entry, including one arriving this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            update_en     <= 1'b0;
            update_val    <= 1'b0;
            mispredict    <= 1'b0;
            mispredict_pc <= '0;
            resolved_cnt  <= '0;
            mispred_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            update_en  <= deq;
            update_val <= deq && res_taken;
            mispredict <= mis;
            if (mis) begin
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                mispredict_pc <= head_pc;
            end else begin
                if (enq) tail <= tail + PTR_W'(1);
                if (deq) head <= head + PTR_W'(1);
                count <= count + CNT_W'(enq) - CNT_W'(deq);
            end
            if (deq && (resolved_cnt != '1)) resolved_cnt <= resolved_cnt + 32'd1;
            if (mis && (mispred_cnt != '1))  mispred_cnt  <= mispred_cnt + 32'd1;
        end
    end

    // Payload storage needs no reset; occupancy tracking decides what is valid.
    always_ff @(posedge clk) begin
        if (enq && !mis) begin
            pc_mem[tail]    <= pred_pc;
            taken_mem[tail] <= pred_taken;
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: FIFO order, wrap, flush, saturation and async reset.
module tb_branch_resolve_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        pred_val, pred_taken, res_val, res_taken;
    logic [31:0] pred_pc;
    logic        pred_rdy, res_rdy, update_en, update_val, mispredict;
    logic [31:0] mispredict_pc, resolved_cnt, mispred_cnt;
    logic [3:0]  count;

    int vectors = 0;
    int miscompares = 0;
    logic [32:0] mq [$];
    logic [31:0] exp_pc;

    branch_resolve_queue #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .pred_val(pred_val), .pred_rdy(pred_rdy), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_val(res_val), .res_rdy(res_rdy), .res_taken(res_taken),
        .update_en(update_en), .update_val(update_val),
        .mispredict(mispredict), .mispredict_pc(mispredict_pc),
        .count(count), .resolved_cnt(resolved_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_val = 1'b0;
        res_val  = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_pred_rdy"}, 32'(pred_rdy), 32'd0);
        chk({tag, "_res_rdy"}, 32'(res_rdy), 32'd0);
        chk({tag, "_update_en"}, 32'(update_en), 32'd0);
        chk({tag, "_update_val"}, 32'(update_val), 32'd0);
        chk({tag, "_mispredict"}, 32'(mispredict), 32'd0);
        chk({tag, "_mispredict_pc"}, mispredict_pc, 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_resolved_cnt"}, resolved_cnt, 32'd0);
        chk({tag, "_mispred_cnt"}, mispred_cnt, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        pred_val = 1'b0; pred_pc = '0; pred_taken = 1'b0;
        res_val = 1'b0; res_taken = 1'b0;
        #3;
        all_zero("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_rst_pred_rdy", 32'(pred_rdy), 32'd1);
        chk("post_rst_res_rdy", 32'(res_rdy), 32'd0);

        // Three branches, resolved back to back with correct outcomes
        pred_val = 1'b1; pred_pc = 32'h100; pred_taken = 1'b1; tick();
        chk("t1_count1", 32'(count), 32'd1);
        chk("t1_res_rdy", 32'(res_rdy), 32'd1);
        pred_pc = 32'h104; pred_taken = 1'b0; tick();
        chk("t1_count2", 32'(count), 32'd2);
        pred_pc = 32'h108; pred_taken = 1'b1; tick();
        chk("t1_count3", 32'(count), 32'd3);
        pred_val = 1'b0; res_val = 1'b1; res_taken = 1'b1; tick();
        chk("t1_count_r1", 32'(count), 32'd2);
        chk("t1_ue1", 32'(update_en), 32'd1);
        chk("t1_uv1", 32'(update_val), 32'd1);
        chk("t1_mis1", 32'(mispredict), 32'd0);
        res_taken = 1'b0; tick();
        chk("t1_count_r2", 32'(count), 32'd1);
        chk("t1_ue2", 32'(update_en), 32'd1);
        chk("t1_uv2", 32'(update_val), 32'd0);
        chk("t1_mis2", 32'(mispredict), 32'd0);
        res_taken = 1'b1; tick();
        chk("t1_count_r3", 32'(count), 32'd0);
        chk("t1_ue3", 32'(update_en), 32'd1);
        chk("t1_uv3", 32'(update_val), 32'd1);
        chk("t1_mis3", 32'(mispredict), 32'd0);
        idle(); tick();
        chk("t1_ue_off", 32'(update_en), 32'd0);
        chk("t1_res_rdy_empty", 32'(res_rdy), 32'd0);
        chk("t1_resolved", resolved_cnt, 32'd3);
        chk("t1_mispred", mispred_cnt, 32'd0);

        // Fill, full-cycle rejection, then 20 pairs across the pointer wrap
        for (int i = 0; i < 8; i++) begin
            pred_val = 1'b1; pred_pc = 32'h1000 + 32'(4 * i); pred_taken = i[0];
            mq.push_back({pred_pc, pred_taken});
            tick();
        end
        chk("t2_full_count", 32'(count), 32'd8);
        chk("t2_full_pred_rdy", 32'(pred_rdy), 32'd0);
        pred_pc = 32'hDEAD; pred_taken = 1'b1;
        res_val = 1'b1; res_taken = mq[0][0];
        void'(mq.pop_front());
        tick();
        chk("t2_full_res_count", 32'(count), 32'd7);
        chk("t2_full_res_ue", 32'(update_en), 32'd1);
        chk("t2_full_res_uv", 32'(update_val), 32'd0);
        chk("t2_full_res_mis", 32'(mispredict), 32'd0);
        chk("t2_pred_rdy_again", 32'(pred_rdy), 32'd1);
        for (int k = 0; k < 20; k++) begin
            res_taken = mq[0][0];
            void'(mq.pop_front());
            pred_pc = 32'h2000 + 32'(4 * k); pred_taken = (k % 3 == 0);
            mq.push_back({pred_pc, pred_taken});
            tick();
            chk("t2_pair_mis", 32'(mispredict), 32'd0);
            chk("t2_pair_count", 32'(count), 32'd7);
        end
        pred_val = 1'b0; res_taken = ~mq[0][0]; exp_pc = mq[0][32:1];
        mq.delete();
        tick();
        chk("t2_order_mis", 32'(mispredict), 32'd1);
        chk("t2_order_pc", mispredict_pc, exp_pc);
        chk("t2_flush_count", 32'(count), 32'd0);
        chk("t2_flush_pred_rdy", 32'(pred_rdy), 32'd0);
        idle(); tick();
        chk("t2_run_pred_rdy", 32'(pred_rdy), 32'd1);
        chk("t2_run_mis", 32'(mispredict), 32'd0);
        chk("t2_resolved", resolved_cnt, 32'd25);
        chk("t2_mispred", mispred_cnt, 32'd1);

        // Mispredict with a wrong-path enqueue in the same cycle
        pred_val = 1'b1; pred_pc = 32'h200; pred_taken = 1'b0; tick();
        pred_pc = 32'h204; pred_taken = 1'b1; tick();
        pred_pc = 32'h208; pred_taken = 1'b0; res_val = 1'b1; res_taken = 1'b1; tick();
        chk("t3_mis", 32'(mispredict), 32'd1);
        chk("t3_mis_pc", mispredict_pc, 32'h200);
        chk("t3_ue", 32'(update_en), 32'd1);
        chk("t3_uv", 32'(update_val), 32'd1);
        chk("t3_pred_rdy", 32'(pred_rdy), 32'd0);
        chk("t3_res_rdy", 32'(res_rdy), 32'd0);
        chk("t3_count", 32'(count), 32'd0);
        idle(); tick();
        chk("t3_run_pred_rdy", 32'(pred_rdy), 32'd1);
        chk("t3_run_res_rdy", 32'(res_rdy), 32'd0);
        chk("t3_run_count", 32'(count), 32'd0);
        chk("t3_mis_pc_hold", mispredict_pc, 32'h200);

        // Resolve on empty is ignored; concurrent enqueue on empty is accepted
        res_val = 1'b1; res_taken = 1'b1; tick();
        chk("t4_empty_ue", 32'(update_en), 32'd0);
        chk("t4_empty_resolved", resolved_cnt, 32'd26);
        pred_val = 1'b1; pred_pc = 32'h300; pred_taken = 1'b1; res_taken = 1'b0; tick();
        chk("t4_both_count", 32'(count), 32'd1);
        chk("t4_both_ue", 32'(update_en), 32'd0);
        chk("t4_both_mis", 32'(mispredict), 32'd0);
        pred_val = 1'b0; res_taken = 1'b1; tick();
        chk("t4_drain_count", 32'(count), 32'd0);
        chk("t4_drain_uv", 32'(update_val), 32'd1);
        idle(); tick();

        // Saturation of the mispredict counter
        force dut.mispred_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.mispred_cnt;
        chk("t5_forced", mispred_cnt, 32'hFFFF_FFFE);
        for (int j = 0; j < 2; j++) begin
            pred_val = 1'b1; pred_pc = 32'h400 + 32'(4 * j); pred_taken = 1'b0; tick();
            pred_val = 1'b0; res_val = 1'b1; res_taken = 1'b1; tick();
            chk("t5_mis", 32'(mispredict), 32'd1);
            chk("t5_sat", mispred_cnt, 32'hFFFF_FFFF);
            idle(); tick();
        end
        chk("t5_resolved", resolved_cnt, 32'd29);

        // Asynchronous reset mid-cycle with live state and a pending update
        for (int i = 0; i < 6; i++) begin
            pred_val = 1'b1; pred_pc = 32'h500 + 32'(4 * i); pred_taken = 1'b1; tick();
        end
        pred_val = 1'b0; res_val = 1'b1; res_taken = 1'b1; tick();
        res_val = 1'b0;
        chk("t6_pre_count", 32'(count), 32'd5);
        chk("t6_pre_ue", 32'(update_en), 32'd1);
        chk("t6_pre_resolved", resolved_cnt, 32'd30);
        #3;
        reset = 1'b0;
        #1;
        all_zero("t6_rst");
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("t6_post_count", 32'(count), 32'd0);
        chk("t6_post_ue", 32'(update_en), 32'd0);
        chk("t6_post_pred_rdy", 32'(pred_rdy), 32'd1);
        tick();
        chk("t6_post_ue2", 32'(update_en), 32'd0);
        chk("t6_post_mis_cnt", mispred_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
